seq_div_16by8: RTL and testbench

- Iterative unsigned restoring divider, 16-bit dividend by 8-bit divisor; the inverse operation of the 8x8 approximate multiplier datapath.
- Used to recover operands and to compute exact/approximate ratios for error-metric evaluation (e.g. a product divided by an operand).
- Valid/ready handshake on both sides; one quotient bit per cycle; a single operation in flight.

---
 rtl/seq_div_16by8_pkg.sv | 17 +
 rtl/seq_div_16by8_div_step.sv | 26 ++
 rtl/seq_div_16by8.sv | 126 ++++++++++++
 tb/tb_seq_div_16by8.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_16by8_pkg.sv
// Shared types and constants for the iterative 16/8 restoring divider.
// The optional DIV_APPROX_EN build is selected in the top file.
package seq_div_16by8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam int DW_DEF = 16;
  localparam int SW_DEF = 8;

  // Wide enough for any practical DW; the top slices off its own width.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_div_16by8_div_step.sv
// One combinational restoring-division iteration: shift {R,Q} left, trial
// subtract the divisor, keep the difference only when it does not borrow.
module seq_div_16by8_div_step #(
  parameter int DW = 16,
  parameter int SW = 8
) (
  input  logic [SW:0]   rem_i,
  input  logic [DW-1:0] quo_i,
  input  logic [SW-1:0] div_i,
  output logic [SW:0]   rem_o,
  output logic [DW-1:0] quo_o
);

  logic [SW+1:0] shifted;
  logic [SW:0]   trial;
  logic          noBorrow;

  always_comb begin
    shifted  = {rem_i, quo_i[DW-1]};
    noBorrow = (shifted >= {2'b00, div_i});
    trial    = shifted[SW:0] - {1'b0, div_i};
    rem_o    = noBorrow ? trial : shifted[SW:0];
    quo_o    = {quo_i[DW-2:0], noBorrow};
  end

endmodule

// File: rtl/seq_div_16by8.sv
// Iterative unsigned 16/8 restoring divider with valid/ready handshakes.
// Define DIV_APPROX_EN to stop APPROX_BITS iterations early (quotient LSBs zero).
module seq_div_16by8
  import seq_div_16by8_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int SW          = SW_DEF,
  parameter int APPROX_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [SW-1:0] remainder,
  output logic          div_by_zero
);

`ifdef DIV_APPROX_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif

  localparam int SKIP  = APPROX_ON ? APPROX_BITS : 0;
  localparam int ITERS = DW - SKIP;
  localparam int CNT_W = $clog2(DW + 1);

  state_e             state_q;
  logic [DW-1:0]      quo_q;
  logic [SW-1:0]      div_q;
  logic [SW:0]        rem_q;
  logic [CNT_W-1:0]   iterCnt_q;
  logic               inReady_q;
  logic               outValid_q;
  logic [DW-1:0]      quotOut_q;
  logic [SW-1:0]      remOut_q;
  logic               dbz_q;

  logic [DW-1:0]      quo_d;
  logic [SW:0]        rem_d;

  seq_div_16by8_div_step #(
    .DW(DW),
    .SW(SW)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(rem_d),
    .quo_o(quo_d)
  );

  // A zero divisor is detected in the first CALC cycle so its result
  // appears one edge after the accept, like any other first iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      quo_q      <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      iterCnt_q  <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      quotOut_q  <= '0;
      remOut_q   <= '0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            quo_q     <= dividend;
            div_q     <= divisor;
            rem_q     <= '0;
            iterCnt_q <= '0;
            inReady_q <= 1'b0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (div_q == '0) begin
            quotOut_q  <= DIV_ZERO_QUOT[DW-1:0];
            remOut_q   <= quo_q[SW-1:0];
            dbz_q      <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            iterCnt_q <= iterCnt_q + 1'b1;
            if (iterCnt_q == CNT_W'(ITERS - 1)) begin
              quotOut_q  <= quo_d << SKIP;
              remOut_q   <= rem_d[SW-1:0];
              dbz_q      <= 1'b0;
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = outValid_q;
  assign quotient    = quotOut_q;
  assign remainder   = remOut_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Directed, table-driven bench for seq_div_16by8 plus hand-written sequences
// for backpressure, ignored in_valid and mid-operation reset.
module tb_seq_div_16by8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] expQ;
    logic [7:0]  expR;
    logic        expDbz;
    int          expLat;
  } vec_t;

  vec_t vecs [8];

  seq_div_16by8 dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Offers one operand pair, then counts edges from the accept edge until
  // out_valid; optionally keeps driving junk in_valid pulses while waiting.
  task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs,
                               input bit noise, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = noise;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (noise) begin
        dividend = 16'($urandom);
        divisor  = 8'($urandom_range(1, 255));
      end
    end
  endtask

  task automatic consume();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("in_ready after handshake", in_ready, 1);
    checkOutput("out_valid after handshake", out_valid, 0);
  endtask

  // Applies the approximate-mode transform to an exact expectation.
  task automatic adjustExpect(inout vec_t v);
`ifdef DIV_APPROX_EN
    logic [15:0] top;
    if (v.dvs != 0) begin
      top      = v.dvd >> 4;
      v.expQ   = 16'((top / v.dvs) << 4);
      v.expR   = 8'(top % v.dvs);
      v.expLat = 12;
    end
`else
    v.expLat = v.expLat;
`endif
  endtask

  initial begin
    vec_t v;
    int lat;
    logic [15:0] heldQ;
    logic [7:0]  heldR;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs[0] = '{16'd200,   8'd7,   16'd28,     8'd4,    1'b0, 16};
    vecs[1] = '{16'd65535, 8'd1,   16'd65535,  8'd0,    1'b0, 16};
    vecs[2] = '{16'd65535, 8'd255, 16'd257,    8'd0,    1'b0, 16};
    vecs[3] = '{16'd1000,  8'd0,   16'hFFFF,   8'hE8,   1'b1, 1};
    vecs[4] = '{16'd12345, 8'd100, 16'd123,    8'd45,   1'b0, 16};
    vecs[5] = '{16'd0,     8'd5,   16'd0,      8'd0,    1'b0, 16};
    vecs[6] = '{16'd254,   8'd255, 16'd0,      8'd254,  1'b0, 16};
    vecs[7] = '{16'd9,     8'd2,   16'd4,      8'd1,    1'b0, 16};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset quotient", quotient, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      adjustExpect(v);
      applyStimulus(v.dvd, v.dvs, 1'b0, lat);
      $display("[TB] vector %0d: %0d / %0d", i, v.dvd, v.dvs);
      checkOutput("latency", lat, v.expLat);
      checkOutput("quotient", quotient, v.expQ);
      checkOutput("remainder", remainder, v.expR);
      checkOutput("div_by_zero", div_by_zero, v.expDbz);
      checkOutput("in_ready low in DONE", in_ready, 0);
      consume();
    end

    v = '{16'd50000, 8'd13, 16'd3846, 8'd2, 1'b0, 16};
    adjustExpect(v);
    applyStimulus(v.dvd, v.dvs, 1'b1, lat);
    checkOutput("backpressure latency", lat, v.expLat);
    checkOutput("backpressure quotient", quotient, v.expQ);
    checkOutput("backpressure remainder", remainder, v.expR);
    heldQ = quotient;
    heldR = remainder;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
      checkOutput("held out_valid", out_valid, 1);
      checkOutput("held quotient", quotient, v.expQ);
      checkOutput("held remainder", remainder, v.expR);
    end
    checkOutput("held vs first quotient", quotient, heldQ);
    checkOutput("held vs first remainder", remainder, heldR);
    consume();

    dividend = 16'd40000;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("abort in_ready", in_ready, 1);
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort quotient", quotient, 0);
    checkOutput("abort remainder", remainder, 0);
    checkOutput("abort div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checkOutput("no result after abort", out_valid, 0);
    end

    v = '{16'd9, 8'd2, 16'd4, 8'd1, 1'b0, 16};
    adjustExpect(v);
    applyStimulus(v.dvd, v.dvs, 1'b0, lat);
    checkOutput("post-reset latency", lat, v.expLat);
    checkOutput("post-reset quotient", quotient, v.expQ);
    checkOutput("post-reset remainder", remainder, v.expR);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
